// File: rtl/keypad_debouncer_pkg.sv
// rtl/keypad_debouncer_pkg.sv - shared types and sizing helpers for the keypad debouncer
package keypad_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  // One spare bit above $clog2 so the terminal value itself always fits.
  function automatic int cnt_w(input int max);
    return $clog2(max) + 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_debouncer_if.sv
// rtl/keypad_debouncer_if.sv - scanner-side inputs and qualified key outputs of the debouncer
interface keypad_debouncer_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] sig_in;
  logic              key_pressed;
  logic [CODE_W-1:0] sig_out;
  logic              key_valid;
  logic              key_repeat;
  logic              key_held;
  logic              key_released;

  modport master (
    output sig_in, key_pressed,
    input  sig_out, key_valid, key_repeat, key_held, key_released
  );

  modport slave (
    input  sig_in, key_pressed,
    output sig_out, key_valid, key_repeat, key_held, key_released
  );
endinterface

// File: rtl/keypad_debouncer_hold_timer.sv
// rtl/keypad_debouncer_hold_timer.sv - up-counter with clear/enable and equality terminal flag
module hold_timer
  import keypad_debouncer_pkg::*;
#(
  parameter  int MAX = 2,
  localparam int W   = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_done = (r_cnt == i_term);

endmodule

// File: rtl/keypad_debouncer.sv
// rtl/keypad_debouncer.sv - press/release qualification FSM with optional typematic repeat
module keypad_debouncer
  import keypad_debouncer_pkg::*;
#(
  parameter int CODE_W         = 4,
  parameter int STABLE_CYCLES  = 960000,
  parameter int RELEASE_CYCLES = 960000,
  parameter int REPEAT_EN      = 0,
  parameter int REPEAT_DELAY   = 24000000,
  parameter int REPEAT_RATE    = 4800000
) (
  input  logic                clk,
  input  logic                reset,
  keypad_debouncer_if.slave   bus
);

  localparam int PR_MAX = max2(STABLE_CYCLES, RELEASE_CYCLES);
  localparam int PR_W   = cnt_w(PR_MAX);
  localparam int RP_MAX = max2(REPEAT_DELAY, REPEAT_RATE);
  localparam int RP_W   = cnt_w(RP_MAX);

  localparam logic [PR_W-1:0] STABLE_TERM  = PR_W'(STABLE_CYCLES - 1);
  localparam logic [PR_W-1:0] RELEASE_TERM = PR_W'(RELEASE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_TERM   = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RATE_TERM    = RP_W'(REPEAT_RATE - 1);

  deb_state_t        r_state;
  deb_state_t        w_next;
  logic [CODE_W-1:0] r_cand;
  logic [CODE_W-1:0] r_sig_out;
  logic              r_valid;
  logic              r_repeat;
  logic              r_held;
  logic              r_released;
  logic              r_rpt_first;

  logic              w_match;
  logic              w_pr_clear, w_pr_en, w_pr_done;
  logic              w_rp_clear, w_rp_en, w_rp_done;
  logic [PR_W-1:0]   w_pr_term;
  logic [RP_W-1:0]   w_rp_term;
  logic              w_load_cand, w_accept, w_fire_rpt, w_fire_rel;

  assign w_match   = (bus.sig_in == r_cand);
  assign w_pr_term = (r_state == RELEASE_WAIT) ? RELEASE_TERM : STABLE_TERM;
  assign w_rp_term = r_rpt_first ? DELAY_TERM : RATE_TERM;

  // Press and release waits never overlap, so they share one timer.
  hold_timer #(.MAX(PR_MAX)) u_pr_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_pr_clear),
    .i_en    (w_pr_en),
    .i_term  (w_pr_term),
    .o_done  (w_pr_done)
  );

  hold_timer #(.MAX(RP_MAX)) u_rp_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_rp_clear),
    .i_en    (w_rp_en),
    .i_term  (w_rp_term),
    .o_done  (w_rp_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:         if (bus.key_pressed) w_next = PRESS_WAIT;
      PRESS_WAIT: begin
        if (!bus.key_pressed)           w_next = IDLE;
        else if (w_match && w_pr_done)  w_next = HELD;
      end
      HELD:         if (!bus.key_pressed) w_next = RELEASE_WAIT;
      RELEASE_WAIT: begin
        if (bus.key_pressed)            w_next = HELD;
        else if (w_pr_done)             w_next = IDLE;
      end
      default:      w_next = IDLE;
    endcase
  end

  always_comb begin
    w_pr_clear  = 1'b0;
    w_pr_en     = 1'b0;
    w_rp_clear  = 1'b0;
    w_rp_en     = 1'b0;
    w_load_cand = 1'b0;
    w_accept    = 1'b0;
    w_fire_rpt  = 1'b0;
    w_fire_rel  = 1'b0;
    case (r_state)
      IDLE: begin
        w_pr_clear  = 1'b1;
        w_rp_clear  = 1'b1;
        w_load_cand = bus.key_pressed;
      end
      PRESS_WAIT: begin
        w_rp_clear = 1'b1;
        if (!bus.key_pressed) begin
          w_pr_clear = 1'b1;
        end else if (!w_match) begin
          w_pr_clear  = 1'b1;
          w_load_cand = 1'b1;
        end else if (w_pr_done) begin
          w_pr_clear = 1'b1;
          w_accept   = 1'b1;
        end else begin
          w_pr_en = 1'b1;
        end
      end
      HELD: begin
        w_pr_clear = 1'b1;
        // A falling key_pressed wins over a repeat landing on the same edge.
        if (REPEAT_EN != 0 && bus.key_pressed) begin
          if (w_rp_done) begin
            w_fire_rpt = 1'b1;
            w_rp_clear = 1'b1;
          end else begin
            w_rp_en = 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (bus.key_pressed) begin
          w_pr_clear = 1'b1;
        end else if (w_pr_done) begin
          w_pr_clear = 1'b1;
          w_fire_rel = 1'b1;
        end else begin
          w_pr_en = 1'b1;
        end
      end
      default: begin
        w_pr_clear = 1'b1;
        w_rp_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand      <= '0;
      r_sig_out   <= '0;
      r_valid     <= 1'b0;
      r_repeat    <= 1'b0;
      r_held      <= 1'b0;
      r_released  <= 1'b0;
      r_rpt_first <= 1'b0;
    end else begin
      r_valid    <= w_accept | w_fire_rpt;
      r_repeat   <= w_fire_rpt;
      r_released <= w_fire_rel;
      if (w_load_cand) r_cand <= bus.sig_in;
      if (w_accept) begin
        r_sig_out   <= r_cand;
        r_held      <= 1'b1;
        r_rpt_first <= 1'b1;
      end else begin
        if (w_fire_rel) r_held      <= 1'b0;
        if (w_fire_rpt) r_rpt_first <= 1'b0;
      end
    end
  end

  assign bus.sig_out      = r_sig_out;
  assign bus.key_valid    = r_valid;
  assign bus.key_repeat   = r_repeat;
  assign bus.key_held     = r_held;
  assign bus.key_released = r_released;

endmodule

// File: tb/tb_keypad_debouncer.sv
// tb/tb_keypad_debouncer.sv - bench for keypad_debouncer with and without auto-repeat
module tb_keypad_debouncer;

  localparam int S  = 20;
  localparam int R  = 10;
  localparam int D  = 50;
  localparam int RT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] code = 4'h0;
  logic       pressed = 1'b0;

  always #5 clk = ~clk;

  keypad_debouncer_if #(.CODE_W(4)) if_a ();
  keypad_debouncer_if #(.CODE_W(4)) if_b ();

  assign if_a.sig_in      = code;
  assign if_a.key_pressed = pressed;
  assign if_b.sig_in      = code;
  assign if_b.key_pressed = pressed;

  keypad_debouncer #(.CODE_W(4), .STABLE_CYCLES(S), .RELEASE_CYCLES(R), .REPEAT_EN(0),
                     .REPEAT_DELAY(D), .REPEAT_RATE(RT)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  keypad_debouncer #(.CODE_W(4), .STABLE_CYCLES(S), .RELEASE_CYCLES(R), .REPEAT_EN(1),
                     .REPEAT_DELAY(D), .REPEAT_RATE(RT)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: run lengths of stable input, counted per sampled edge.
  logic       m_held[2];
  int         m_run[2];
  logic [3:0] m_cand[2];
  int         m_low[2];
  int         m_ticks[2];
  logic       m_first[2];
  logic [3:0] m_sig[2];
  logic       e_valid[2], e_rep[2], e_rel[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_held[k] = 0; m_run[k] = 0; m_cand[k] = 0; m_low[k] = 0; m_ticks[k] = 0;
      m_first[k] = 0; m_sig[k] = 0; e_valid[k] = 0; e_rep[k] = 0; e_rel[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit rep_en, input logic [3:0] c, input logic p);
    e_valid[k] = 0; e_rep[k] = 0; e_rel[k] = 0;
    if (!m_held[k]) begin
      if (!p) m_run[k] = 0;
      else if (m_run[k] > 0 && c == m_cand[k]) m_run[k]++;
      else begin m_cand[k] = c; m_run[k] = 1; end
      if (m_run[k] == S + 1) begin
        m_held[k] = 1; m_sig[k] = m_cand[k]; e_valid[k] = 1;
        m_ticks[k] = 0; m_first[k] = 1; m_low[k] = 0; m_run[k] = 0;
      end
    end else if (m_low[k] == 0) begin
      if (!p) m_low[k] = 1;
      else if (rep_en) begin
        m_ticks[k]++;
        if (m_ticks[k] == (m_first[k] ? D : RT)) begin
          e_valid[k] = 1; e_rep[k] = 1; m_ticks[k] = 0; m_first[k] = 0;
        end
      end
    end else begin
      if (p) m_low[k] = 0;
      else begin
        m_low[k]++;
        if (m_low[k] == R + 1) begin e_rel[k] = 1; m_held[k] = 0; m_run[k] = 0; end
      end
    end
  endtask

  task automatic compare_model(input int k, input int cyc);
    string t;
    t = (k == 0) ? "a" : "b";
    if (k == 0) begin
      chk($sformatf("rand_valid_%s@%0d", t, cyc), 32'(if_a.key_valid), 32'(e_valid[0]));
      chk($sformatf("rand_repeat_%s@%0d", t, cyc), 32'(if_a.key_repeat), 32'(e_rep[0]));
      chk($sformatf("rand_released_%s@%0d", t, cyc), 32'(if_a.key_released), 32'(e_rel[0]));
      chk($sformatf("rand_held_%s@%0d", t, cyc), 32'(if_a.key_held), 32'(m_held[0]));
      chk($sformatf("rand_sig_out_%s@%0d", t, cyc), 32'(if_a.sig_out), 32'(m_sig[0]));
    end else begin
      chk($sformatf("rand_valid_%s@%0d", t, cyc), 32'(if_b.key_valid), 32'(e_valid[1]));
      chk($sformatf("rand_repeat_%s@%0d", t, cyc), 32'(if_b.key_repeat), 32'(e_rep[1]));
      chk($sformatf("rand_released_%s@%0d", t, cyc), 32'(if_b.key_released), 32'(e_rel[1]));
      chk($sformatf("rand_held_%s@%0d", t, cyc), 32'(if_b.key_held), 32'(m_held[1]));
      chk($sformatf("rand_sig_out_%s@%0d", t, cyc), 32'(if_b.sig_out), 32'(m_sig[1]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sig_out_a"}, 32'(if_a.sig_out), 0);
    chk({tag, "_valid_a"}, 32'(if_a.key_valid), 0);
    chk({tag, "_held_a"}, 32'(if_a.key_held), 0);
    chk({tag, "_released_a"}, 32'(if_a.key_released), 0);
    chk({tag, "_sig_out_b"}, 32'(if_b.sig_out), 0);
    chk({tag, "_valid_b"}, 32'(if_b.key_valid), 0);
    chk({tag, "_repeat_b"}, 32'(if_b.key_repeat), 0);
    chk({tag, "_held_b"}, 32'(if_b.key_held), 0);
  endtask

  task automatic do_reset();
    pressed = 0; code = 0; reset = 1;
    tick();
    reset = 0;
  endtask

  typedef struct {
    int         n;
    logic [3:0] code;
    logic       pr;
    int         valids;
    int         rels;
    logic       held;
    logic [3:0] sig;
  } vec_t;

  function automatic vec_t mk(int n, logic [3:0] c, logic p, int v, int r, logic h, logic [3:0] s);
    vec_t x;
    x.n = n; x.code = c; x.pr = p; x.valids = v; x.rels = r; x.held = h; x.sig = s;
    return x;
  endfunction

  vec_t vt[$];

  initial begin
    int va, vb, ra;
    int cyc;
    int len;

    // Reset held two edges, then idle.
    reset = 1;
    tick(); tick();
    reset = 0;
    for (int i = 0; i < 10; i++) tick();
    check_all_zero("reset");
    chk("reset_state_a", 32'(dut_a.r_state), 0);

    vt.push_back(mk(40, 4'hA, 1, 1, 0, 1, 4'hA));
    vt.push_back(mk(15, 4'hA, 0, 0, 1, 0, 4'hA));
    for (int i = 0; i < 4; i++) begin
      vt.push_back(mk(1, 4'h5, 1, 0, 0, 0, 4'hA));
      vt.push_back(mk(1, 4'h5, 0, 0, 0, 0, 4'hA));
    end
    vt.push_back(mk(20, 4'h5, 1, 0, 0, 0, 4'hA));
    vt.push_back(mk(1,  4'h5, 1, 1, 0, 1, 4'h5));
    vt.push_back(mk(10, 4'h5, 0, 0, 0, 1, 4'h5));
    vt.push_back(mk(1,  4'h5, 0, 0, 1, 0, 4'h5));
    vt.push_back(mk(15, 4'h3, 1, 0, 0, 0, 4'h5));
    vt.push_back(mk(21, 4'h7, 1, 1, 0, 1, 4'h7));
    vt.push_back(mk(5,  4'h9, 1, 0, 0, 1, 4'h7));
    vt.push_back(mk(5,  4'h9, 0, 0, 0, 1, 4'h7));
    vt.push_back(mk(5,  4'h9, 1, 0, 0, 1, 4'h7));
    vt.push_back(mk(12, 4'h9, 0, 0, 1, 0, 4'h7));

    for (int v = 0; v < vt.size(); v++) begin
      code = vt[v].code; pressed = vt[v].pr;
      va = 0; vb = 0; ra = 0;
      for (int c = 0; c < vt[v].n; c++) begin
        tick();
        va += int'(if_a.key_valid);
        vb += int'(if_b.key_valid);
        ra += int'(if_a.key_released);
      end
      chk($sformatf("vec%0d_valids_a", v), 32'(va), 32'(vt[v].valids));
      chk($sformatf("vec%0d_valids_b", v), 32'(vb), 32'(vt[v].valids));
      chk($sformatf("vec%0d_released_a", v), 32'(ra), 32'(vt[v].rels));
      chk($sformatf("vec%0d_held_a", v), 32'(if_a.key_held), 32'(vt[v].held));
      chk($sformatf("vec%0d_sig_out_a", v), 32'(if_a.sig_out), 32'(vt[v].sig));
    end

    // Auto-repeat: hold 4'hC for 120 edges; index 0 is the edge that first sees the press.
    do_reset();
    code = 4'hC; pressed = 1;
    for (int i = 0; i < 120; i++) begin
      bit exp_b_v, exp_b_r;
      tick();
      exp_b_r = (i == 70 || i == 85 || i == 100 || i == 115);
      exp_b_v = exp_b_r || (i == 20);
      chk($sformatf("rpt_valid_b@%0d", i), 32'(if_b.key_valid), 32'(exp_b_v));
      chk($sformatf("rpt_repeat_b@%0d", i), 32'(if_b.key_repeat), 32'(exp_b_r));
      chk($sformatf("rpt_valid_a@%0d", i), 32'(if_a.key_valid), 32'(i == 20));
      chk($sformatf("rpt_repeat_a@%0d", i), 32'(if_a.key_repeat), 0);
    end
    chk("rpt_sig_out_b", 32'(if_b.sig_out), 32'hC);

    // Reset while held aborts everything without a release pulse.
    do_reset();
    code = 4'hC; pressed = 1;
    for (int i = 0; i < 60; i++) tick();
    chk("midrst_held_before_b", 32'(if_b.key_held), 1);
    reset = 1;
    tick();
    check_all_zero("midrst");
    reset = 0; pressed = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("midrst_released_a@%0d", i), 32'(if_a.key_released), 0);
      chk($sformatf("midrst_released_b@%0d", i), 32'(if_b.key_released), 0);
      chk($sformatf("midrst_held_b@%0d", i), 32'(if_b.key_held), 0);
    end

    // Random segments against the reference model.
    do_reset();
    model_reset();
    cyc = 0;
    while (cyc < 5000) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1;
        tick();
        reset = 0;
        model_reset();
        compare_model(0, cyc);
        compare_model(1, cyc);
        cyc++;
      end
      code    = 4'($urandom_range(0, 3));
      pressed = ($urandom_range(0, 3) != 0);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 130) : $urandom_range(1, 25);
      for (int c = 0; c < len; c++) begin
        tick();
        model_step(0, 1'b0, code, pressed);
        model_step(1, 1'b1, code, pressed);
        compare_model(0, cyc);
        compare_model(1, cyc);
        cyc++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
